// File: rtl/pdm_deserializer_if.sv
// Sample stream from the PDM deserializer to its consumer: head-of-buffer word, channel tag and
// valid/ready handshake.
interface pdm_deserializer_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] data;
    logic             data_ch;
    logic             data_valid;
    logic             data_ready;

    modport master (output data, output data_ch, output data_valid, input data_ready);
    modport slave  (input data, input data_ch, input data_valid, output data_ready);
endinterface

// File: rtl/pdm_deserializer.sv
// PDM microphone front end: mic clock divider, 2-FF input sync, raw/ones-count windowing and a
// 2-entry output buffer. Define STEREO_EN to sample both channels with separate accumulators.
module pdm_deserializer #(
    parameter int CLK_DIV = 50,
    parameter int MODE    = 1,
    parameter int WIDTH   = 16,
    parameter int DECIM   = 128,
    parameter int CHANNEL = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               data_in,
    output logic               pdm_clk_o,
    output logic               pdm_irsel_o,
    output logic               done,
    output logic               overrun,
    pdm_deserializer_if.master bus
);
    localparam int   HALF   = CLK_DIV / 2;
    localparam int   WIN    = (MODE == 1) ? DECIM : WIDTH;
    localparam int   DW     = $clog2(CLK_DIV);
    localparam int   BW     = $clog2(WIN + 1);
    localparam logic CH_BIT = (CHANNEL != 0) ? 1'b1 : 1'b0;
`ifdef STEREO_EN
    localparam int   NCH    = 2;
    localparam logic IRSEL  = 1'b0;
`else
    localparam int   NCH    = 1;
    localparam logic IRSEL  = CH_BIT;
`endif

    logic [1:0]       sync_r;
    logic [DW-1:0]    div_cnt_r;
    logic             pdm_clk_r;
    logic             irsel_r;
    logic             enable_d_r;
    logic [WIDTH-1:0] acc_r  [NCH];
    logic [BW-1:0]    bcnt_r [NCH];
    logic             done_r;
    logic             overrun_r;
    logic [WIDTH:0]   mem_r  [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    logic             samp_a_s;
    logic             samp_b_s;
    logic [NCH-1:0]   samp_s;
    logic [NCH-1:0]   last_s;
    logic [WIDTH-1:0] word_s [NCH];
    logic             push_s;
    logic [WIDTH-1:0] push_word_s;
    logic             push_ch_s;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic             ovf_s;
    logic [1:0]       count_next_s;

    assign samp_a_s = enable && (div_cnt_r == DW'(HALF - 1));
    assign samp_b_s = enable && (div_cnt_r == DW'(CLK_DIV - 1));
`ifdef STEREO_EN
    assign samp_s = {samp_b_s, samp_a_s};
`else
    assign samp_s = (CHANNEL == 0) ? samp_a_s : samp_b_s;
`endif

    // Input synchronizer, mic-clock divider and enable edge history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_r     <= 2'b00;
            div_cnt_r  <= '0;
            pdm_clk_r  <= 1'b0;
            irsel_r    <= IRSEL;
            enable_d_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[0], data_in};
            irsel_r    <= IRSEL;
            enable_d_r <= enable;
            if (enable) begin
                div_cnt_r <= (div_cnt_r == DW'(CLK_DIV - 1)) ? '0 : div_cnt_r + DW'(1);
                // Registered copy of div_cnt<HALF: the first high phase after enable is full length
                pdm_clk_r <= (div_cnt_r < DW'(HALF));
            end else begin
                div_cnt_r <= '0;
                pdm_clk_r <= 1'b0;
            end
        end
    end

    // Word candidates including the current bit, and window completion selection
    always_comb begin
        push_s      = 1'b0;
        push_word_s = '0;
        push_ch_s   = 1'b0;
        last_s      = '0;
        for (int c = 0; c < NCH; c++) begin
            word_s[c] = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (MODE == 0) begin
                word_s[c] = {acc_r[c][WIDTH-2:0], sync_r[1]};
            end else begin
                word_s[c] = acc_r[c] + {{(WIDTH-1){1'b0}}, sync_r[1]};
            end
            last_s[c] = (bcnt_r[c] == BW'(WIN - 1));
            if (samp_s[c] && last_s[c]) begin
                push_s      = 1'b1;
                push_word_s = word_s[c];
                push_ch_s   = (NCH == 2) ? 1'(c) : CH_BIT;
            end else begin
                push_s      = push_s;
            end
        end
    end

    // Per-channel accumulators; disabling discards the partial window
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc_r[c]  <= '0;
                bcnt_r[c] <= '0;
            end
        end else if (!enable) begin
            for (int c = 0; c < NCH; c++) begin
                acc_r[c]  <= '0;
                bcnt_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (samp_s[c] && last_s[c]) begin
                    acc_r[c]  <= '0;
                    bcnt_r[c] <= '0;
                end else if (samp_s[c]) begin
                    acc_r[c]  <= word_s[c];
                    bcnt_r[c] <= bcnt_r[c] + BW'(1);
                end else begin
                    acc_r[c]  <= acc_r[c];
                    bcnt_r[c] <= bcnt_r[c];
                end
            end
        end
    end

    assign pop_s   = (count_r != 2'd0) && bus.data_ready;
    assign full_s  = (count_r == 2'd2);
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign ovf_s   = push_s && full_s && !pop_s;

    // Buffer occupancy update
    always_comb begin
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Output buffer, done pulse and sticky overrun
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_r[0]  <= '0;
            mem_r[1]  <= '0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            done_r  <= push_s;
            count_r <= count_next_s;
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= {push_ch_s, push_word_s};
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (enable && !enable_d_r) begin
                overrun_r <= 1'b0;
            end else if (ovf_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign pdm_clk_o      = pdm_clk_r;
    assign pdm_irsel_o    = irsel_r;
    assign done           = done_r;
    assign overrun        = overrun_r;
    assign bus.data       = mem_r[rd_ptr_r][WIDTH-1:0];
    assign bus.data_ch    = mem_r[rd_ptr_r][WIDTH];
    assign bus.data_valid = (count_r != 2'd0);
endmodule
